// File: rtl/aes_round_ctrl.sv
// Iterative AES-128 round controller: one cipher round per clock through a shared
// encrypt/decrypt datapath, with the key store addressed combinationally by rk_idx.
module aes_round_ctrl (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         decrypt,
  input  logic [127:0] data_in,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk,
  output logic         busy,
  output logic         done,
  output logic [127:0] data_out
);

  localparam int unsigned BlockW    = 128;
  localparam int unsigned RndW      = 4;
  localparam int unsigned NumRounds = 10;

  // byte i of the block (i = 0 is the most significant byte) lives at index 15-i
  typedef logic [15:0][7:0] blockT;
  typedef enum logic [1:0] {IDLE, INIT, ROUND, FINAL} fsmT;

  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] sh;
    acc = 8'h00;
    sh  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) acc = acc ^ sh;
      sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
    end
    return acc;
  endfunction

  // multiplicative inverse as x^254; zero maps to zero
  function automatic logic [7:0] gfInv(input logic [7:0] x);
    logic [7:0] pw;
    logic [7:0] acc;
    pw  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      pw  = gfMul(pw, pw);
      acc = gfMul(acc, pw);
    end
    return acc;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gfInv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] invSbox(input logic [7:0] x);
    return gfInv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic blockT subBytes(input blockT s, input logic inv);
    blockT r;
    for (int i = 0; i < 16; i++) r[4'(i)] = inv ? invSbox(s[4'(i)]) : sbox(s[4'(i)]);
    return r;
  endfunction

  function automatic blockT shiftRows(input blockT s, input logic inv);
    blockT r;
    int src;
    int dst;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        src = row + 4 * ((col + row) % 4);
        dst = row + 4 * col;
        if (inv) r[4'(15 - src)] = s[4'(15 - dst)];
        else     r[4'(15 - dst)] = s[4'(15 - src)];
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] mixCoef(input logic [1:0] k, input logic inv);
    case (k)
      2'd0:    return inv ? 8'h0e : 8'h02;
      2'd1:    return inv ? 8'h0b : 8'h03;
      2'd2:    return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic blockT mixColumns(input blockT s, input logic inv);
    blockT r;
    logic [7:0] acc;
    for (int col = 0; col < 4; col++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gfMul(mixCoef(2'(j - row), inv), s[4'(15 - (j + 4 * col))]);
        r[4'(15 - (row + 4 * col))] = acc;
      end
    end
    return r;
  endfunction

  fsmT               fsmState, fsmNext;
  logic [BlockW-1:0] stateReg, stateNext;
  logic              mode, modeNext;
  logic [RndW-1:0]   rnd, rndNext;
  logic              busyNext, doneNext;
  logic [BlockW-1:0] dataOutNext;
  logic [BlockW-1:0] encSr, decAdd, roundOut, finalOut;

  // Shared round datapath; the final round drops the mix stage
  always_comb begin
    encSr    = shiftRows(subBytes(stateReg, 1'b0), 1'b0);
    decAdd   = subBytes(shiftRows(stateReg, 1'b1), 1'b1) ^ rk;
    roundOut = mode ? mixColumns(decAdd, 1'b1) : (mixColumns(encSr, 1'b0) ^ rk);
    finalOut = mode ? decAdd : (encSr ^ rk);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsmState <= IDLE;
    else        fsmState <= fsmNext;
  end

  always_comb begin
    fsmNext     = fsmState;
    stateNext   = stateReg;
    modeNext    = mode;
    rndNext     = rnd;
    dataOutNext = data_out;
    doneNext    = 1'b0;
    rk_idx      = '0;
    case (fsmState)
      IDLE: begin
        if (start) begin
          stateNext = data_in;
          modeNext  = decrypt;
          rndNext   = RndW'(1);
          fsmNext   = INIT;
        end
      end
      INIT: begin
        rk_idx    = mode ? RndW'(NumRounds) : '0;
        stateNext = stateReg ^ rk;
        fsmNext   = ROUND;
      end
      ROUND: begin
        rk_idx    = mode ? RndW'(NumRounds) - rnd : rnd;
        stateNext = roundOut;
        rndNext   = rnd + RndW'(1);
        if (rnd == RndW'(NumRounds - 1)) fsmNext = FINAL;
      end
      FINAL: begin
        rk_idx      = mode ? '0 : RndW'(NumRounds);
        dataOutNext = finalOut;
        doneNext    = 1'b1;
        fsmNext     = IDLE;
      end
      default: fsmNext = IDLE;
    endcase
    busyNext = (fsmNext != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg <= '0;
      mode     <= 1'b0;
      rnd      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      data_out <= '0;
    end else begin
      stateReg <= stateNext;
      mode     <= modeNext;
      rnd      <= rndNext;
      busy     <= busyNext;
      done     <= doneNext;
      data_out <= dataOutNext;
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Scoreboard bench for aes_round_ctrl: driver pushes expected results, a per-cycle
// monitor checks busy/done/rk_idx/data_out against the operation schedule.
module tb_aes_round_ctrl;

  typedef logic [7:0] byteT;
  typedef logic [15:0][7:0] blkT;
  typedef struct {
    logic [127:0] expOut;
    int           acc;
    bit           dec;
  } expT;

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         decrypt = 1'b0;
  logic [127:0] data_in = '0;
  logic [3:0]   rk_idx;
  logic [127:0] rk;
  logic         busy;
  logic         done;
  logic [127:0] data_out;

  logic [127:0] rkTable [16];
  byteT         sboxT [256];
  byteT         invSboxT [256];

  int           nCmp = 0;
  int           nFail = 0;
  int           cyc = 0;
  expT          sbq [$];
  logic [127:0] lastOut = '0;
  expT          monF;
  int           monD;

  aes_round_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .decrypt(decrypt), .data_in(data_in),
    .rk_idx(rk_idx), .rk(rk), .busy(busy), .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // key store without latency
  assign rk = rkTable[rk_idx];

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic byteT xt(input byteT b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byteT rotl(input byteT b, input int n);
    byteT r;
    r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // S-box tables from walking the multiplicative group with generator 3
  task automatic buildSbox();
    byteT p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ byteT'(p << 1) ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ byteT'(q << 1);
      q = q ^ byteT'(q << 2);
      q = q ^ byteT'(q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rotl(q, 1) ^ rotl(q, 2) ^ rotl(q, 3) ^ rotl(q, 4);
      sboxT[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sboxT[0] = 8'h63;
    for (int i = 0; i < 256; i++) invSboxT[sboxT[i]] = byteT'(i);
  endtask

  task automatic setKey(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    byteT rcon;
    rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sboxT[t[31:24]], sboxT[t[23:16]], sboxT[t[15:8]], sboxT[t[7:0]]} ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end
      w[i] = w[i - 4] ^ t;
    end
    for (int r = 0; r < 16; r++) rkTable[r] = '0;
    for (int r = 0; r <= 10; r++) rkTable[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask

  function automatic blkT modelSub(input blkT s, input bit inv);
    for (int i = 0; i < 16; i++) s[i] = inv ? invSboxT[s[i]] : sboxT[s[i]];
    return s;
  endfunction

  function automatic blkT modelShift(input blkT s);
    blkT t;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) t[15 - (r + 4 * c)] = s[15 - (r + 4 * ((c + r) % 4))];
    return t;
  endfunction

  function automatic blkT modelMix(input blkT s);
    blkT t;
    byteT a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[15 - 4 * c]; a1 = s[14 - 4 * c]; a2 = s[13 - 4 * c]; a3 = s[12 - 4 * c];
      t[15 - 4 * c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      t[14 - 4 * c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      t[13 - 4 * c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      t[12 - 4 * c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return t;
  endfunction

  // row rotation and MixColumns both have order 4, so inverses are three forward steps
  function automatic blkT modelInvShift(input blkT s);
    return modelShift(modelShift(modelShift(s)));
  endfunction

  function automatic blkT modelInvMix(input blkT s);
    return modelMix(modelMix(modelMix(s)));
  endfunction

  function automatic logic [127:0] encModel(input logic [127:0] pt);
    blkT s;
    s = pt ^ rkTable[0];
    for (int r = 1; r <= 9; r++) s = modelMix(modelShift(modelSub(s, 1'b0))) ^ rkTable[r];
    return modelShift(modelSub(s, 1'b0)) ^ rkTable[10];
  endfunction

  function automatic logic [127:0] decModel(input logic [127:0] ct);
    blkT s;
    s = ct ^ rkTable[10];
    for (int r = 9; r >= 1; r--) s = modelInvMix(modelSub(modelInvShift(s), 1'b1) ^ rkTable[r]);
    return modelSub(modelInvShift(s), 1'b1) ^ rkTable[0];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
    nCmp++;
    if (act !== expv) begin
      nFail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
    end
  endtask

  // Monitor: relative cycle d after the accepting edge defines every output
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (sbq.size() != 0) begin
        monF = sbq[0];
        monD = cyc - monF.acc;
        if (monD <= 10) begin
          chk("busy during op", 128'(busy), 128'(1));
          chk("done during op", 128'(done), 128'(0));
          chk("rk_idx", 128'(rk_idx), 128'(monF.dec ? 10 - monD : monD));
          chk("data_out hold", data_out, lastOut);
        end else begin
          chk("done pulse", 128'(done), 128'(1));
          chk("busy at done", 128'(busy), 128'(0));
          chk("rk_idx at done", 128'(rk_idx), 128'(0));
          chk("data_out result", data_out, monF.expOut);
          lastOut = monF.expOut;
          void'(sbq.pop_front());
        end
      end else begin
        chk("busy idle", 128'(busy), 128'(0));
        chk("done idle", 128'(done), 128'(0));
        chk("rk_idx idle", 128'(rk_idx), 128'(0));
        chk("data_out idle hold", data_out, lastOut);
      end
    end
  end

  // Called at a negedge while the DUT is idle or in its done cycle
  task automatic issue(input bit dec, input logic [127:0] din, input logic [127:0] expv,
                       output int acc);
    expT e;
    start   = 1'b1;
    decrypt = dec;
    data_in = din;
    acc      = cyc + 1;
    e.expOut = expv;
    e.acc    = acc;
    e.dec    = dec;
    sbq.push_back(e);
    @(negedge clk);
    start   = 1'b0;
    decrypt = 1'($urandom);
    data_in = rand128();
  endtask

  task automatic waitIdle();
    int g;
    g = 0;
    while (sbq.size() != 0) begin
      @(negedge clk);
      g++;
      if (g > 40) begin
        nCmp++;
        nFail++;
        $display("FAIL idle wait: %0d ops pending, expected 0", sbq.size());
        sbq.delete();
      end
    end
  endtask

  task automatic waitCyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic pulseStart();
    start   = 1'b1;
    decrypt = 1'($urandom);
    data_in = rand128();
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    int acc, acc2;
    bit dec, b2b;
    logic [127:0] din, expv;
    for (int r = 0; r < 16; r++) rkTable[r] = '0;
    buildSbox();
    setKey(FipsKey);

    repeat (3) @(negedge clk);
    chk("reset busy", 128'(busy), 128'(0));
    chk("reset done", 128'(done), 128'(0));
    chk("reset data_out", data_out, 128'(0));
    chk("reset rk_idx", 128'(rk_idx), 128'(0));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // FIPS-197 vector both ways
    issue(1'b0, FipsPt, FipsCt, acc);
    waitIdle();
    issue(1'b1, FipsCt, FipsPt, acc);
    waitIdle();

    // start while busy must be ignored
    issue(1'b0, FipsPt, FipsCt, acc);
    waitCyc(acc + 2);
    pulseStart();
    waitCyc(acc + 6);
    pulseStart();
    waitIdle();

    // asynchronous reset between E5 and E6
    issue(1'b0, FipsPt, FipsCt, acc);
    waitCyc(acc + 5);
    rst_n = 1'b0;
    #1;
    chk("async reset busy", 128'(busy), 128'(0));
    chk("async reset done", 128'(done), 128'(0));
    chk("async reset data_out", data_out, 128'(0));
    sbq.delete();
    lastOut = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(1'b0, FipsPt, FipsCt, acc);
    waitIdle();

    // back-to-back: decrypt presented during the encrypt's done cycle
    issue(1'b0, FipsPt, FipsCt, acc);
    waitCyc(acc + 11);
    issue(1'b1, FipsCt, FipsPt, acc2);
    waitIdle();

    // randomized keys, modes and blocks with occasional back-to-back issue
    for (int n = 0; n < 24; n++) begin
      b2b = (n % 4 != 0) && ($urandom_range(0, 2) == 0);
      if (n % 4 == 0) begin
        waitIdle();
        setKey(rand128());
      end
      dec  = 1'($urandom);
      din  = rand128();
      expv = dec ? decModel(din) : encModel(din);
      if (b2b) waitCyc(acc + 11);
      else begin
        waitIdle();
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      issue(dec, din, expv, acc);
    end
    waitIdle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule
